// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the sequential multiply/divide unit (mult_div_unit).
// The op encoding matches the 2-bit op field driven by the control FSM.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } mdu_state_e;

  // op[1] selects divide, op[0] selects the signed variant.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control FSM (master) and mult_div_unit (slave).
interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  import mdu_pkg::*;

  logic                  start;
  mdu_op_e               op;
  logic [DATA_WIDTH-1:0] Operand1;
  logic [DATA_WIDTH-1:0] Operand2;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  valid;
  logic                  busy;
  logic                  div_by_zero;

  modport master (
    output start, op, Operand1, Operand2,
    input  hi, lo, valid, busy, div_by_zero
  );

  modport slave (
    input  start, op, Operand1, Operand2,
    output hi, lo, valid, busy, div_by_zero
  );

endinterface

// File: rtl/mult_div_unit_cond_neg.sv
// Conditional two's-complement negate: y = neg ? -a : a.
module mdu_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + WIDTH'(1)) : a_i;

endmodule

// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO results.
// Operates on magnitudes, one bit per cycle, and sign-corrects in FINISH.
// Optional macro MDU_EARLY_TERM_EN: multiply finishes as soon as the remaining
// multiplier bits are zero (variable latency, identical results).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  mult_div_unit_if.slave        bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

`ifdef MDU_EARLY_TERM_EN
  localparam bit early_term_en = 1'b1;
`else
  localparam bit early_term_en = 1'b0;
`endif

  mdu_state_e       state_q;
  logic [CW-1:0]    count_q;
  logic             is_div_q, neg_res_q, neg_rem_q, dbz_q;
  logic [2*W-1:0]   acc_q, acc_d;   // mult: product; div: {remainder, dividend/quotient}
  logic [2*W-1:0]   opa_q, opa_d;   // mult: multiplicand shifted left
  logic [W-1:0]     opb_q, opb_d;   // mult: multiplier shifted right; div: divisor
  logic [W-1:0]     hi_q, lo_q;
  logic             valid_q, busy_q, div_by_zero_q;

  logic             op_signed;
  logic [W-1:0]     mag1, mag2;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo_fix, rem_fix;
  logic [W:0]       div_part;
  logic [W-1:0]     div_sub;
  logic             div_ge;

  assign op_signed = op_is_signed(bus.op);

  // Operand magnitudes for the signed ops.
  mdu_cond_neg #(.WIDTH(W)) u_mag1 (.a_i(bus.Operand1), .neg_i(op_signed & bus.Operand1[W-1]), .y_o(mag1));
  mdu_cond_neg #(.WIDTH(W)) u_mag2 (.a_i(bus.Operand2), .neg_i(op_signed & bus.Operand2[W-1]), .y_o(mag2));

  // Sign-corrected results, loaded into HI/LO in FINISH.
  mdu_cond_neg #(.WIDTH(2*W)) u_prod (.a_i(acc_q), .neg_i(neg_res_q), .y_o(prod_fix));
  mdu_cond_neg #(.WIDTH(W)) u_quo (.a_i(acc_q[W-1:0]), .neg_i(neg_res_q), .y_o(quo_fix));
  mdu_cond_neg #(.WIDTH(W)) u_rem (.a_i(acc_q[2*W-1:W]), .neg_i(neg_rem_q), .y_o(rem_fix));

  // Restoring-divide trial: shift the next dividend bit into the partial remainder.
  assign div_part = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_ge   = (div_part >= {1'b0, opb_q});
  assign div_sub  = div_part[W-1:0] - opb_q;

  // One iteration of the selected algorithm.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    if (is_div_q) begin
      acc_d = div_ge ? {div_sub, acc_q[W-2:0], 1'b1}
                     : {div_part[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      if (opb_q[0]) acc_d = acc_q + opa_q;
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      count_q       <= '0;
      is_div_q      <= 1'b0;
      neg_res_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      acc_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            is_div_q  <= op_is_div(bus.op);
            neg_res_q <= op_signed & (bus.Operand1[W-1] ^ bus.Operand2[W-1]);
            neg_rem_q <= op_signed & bus.Operand1[W-1];
            busy_q    <= 1'b1;
            count_q   <= '0;
            opb_q     <= mag2;
            dbz_q     <= 1'b0;
            state_q   <= RUN;
            if (op_is_div(bus.op)) begin
              opa_q <= '0;
              if (bus.Operand2 == '0) begin
                // Raw dividend kept for HI; no iterations needed.
                dbz_q   <= 1'b1;
                acc_q   <= {{W{1'b0}}, bus.Operand1};
                state_q <= FINISH;
              end else begin
                acc_q <= {{W{1'b0}}, mag1};
              end
            end else begin
              acc_q <= '0;
              opa_q <= {{W{1'b0}}, mag1};
              if (early_term_en && mag2 == '0) state_q <= FINISH;
            end
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          opa_q   <= opa_d;
          opb_q   <= opb_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(W - 1)) state_q <= FINISH;
          else if (early_term_en && !is_div_q && opb_d == '0) state_q <= FINISH;
        end
        FINISH: begin
          if (dbz_q) begin
            hi_q <= acc_q[W-1:0];
            lo_q <= '1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*W-1:W];
            lo_q <= prod_fix[W-1:0];
          end
          div_by_zero_q <= dbz_q;
          valid_q       <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, handshake
// corner sequences, and random operations against an arithmetic reference.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mult_div_unit_if #(.DATA_WIDTH(W)) bus ();

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    mdu_op_e        op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic void model(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      MDU_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      MDU_MULT:  begin p = 64'(sa * sb);            hi = p[63:32]; lo = p[31:0]; end
      MDU_DIVU, MDU_DIV: begin
        if (b == 0) begin
          dbz = 1'b1; hi = a; lo = '1;
        end else if (op == MDU_DIVU) begin
          lo = a / b; hi = a % b;
        end else begin
          sq = sa / sb; sr = sa % sb;
          lo = sq[31:0]; hi = sr[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Edges from the accepting edge (counted as 1) to the edge that raises valid.
  function automatic int exp_latency(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint mb;
    int     msb;
    if (op == MDU_DIVU || op == MDU_DIV) return (b == 0) ? 2 : W + 2;
`ifdef MDU_EARLY_TERM_EN
    mb = (op == MDU_MULT) ? longint'($signed(b)) : longint'({32'b0, b});
    if (mb < 0) mb = -mb;
    if (mb == 0) return 2;
    msb = 0;
    for (int i = 0; i < 33; i++) if (mb[i]) msb = i;
    return msb + 3;
`else
    mb  = longint'(a);
    msb = int'(mb[0]);
    return W + 2 + msb - msb;
`endif
  endfunction

  task automatic scramble_inputs();
    bus.op       = mdu_op_e'($urandom_range(0, 3));
    bus.Operand1 = $urandom;
    bus.Operand2 = $urandom;
  endtask

  // Present a request for one cycle; returns after the accepting edge.
  task automatic launch(input string tag, input mdu_op_e op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int edges);
    @(negedge CLK);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    edges = 1;
    check({tag, " busy_after_start"}, 64'(bus.busy), 64'(1));
  endtask

  task automatic wait_valid(inout int edges);
    while (bus.valid !== 1'b1 && edges < 200) begin
      @(posedge CLK);
      #1;
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input int edges, input int lat,
                              input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
    check({tag, " valid"},       64'(bus.valid), 64'(1));
    check({tag, " latency"},     64'(edges),     64'(lat));
    check({tag, " hi"},          64'(bus.hi),    64'(hi));
    check({tag, " lo"},          64'(bus.lo),    64'(lo));
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(dbz));
    check({tag, " busy_low"},    64'(bus.busy),  64'(0));
  endtask

  task automatic run_op(input string tag, input mdu_op_e op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] hi,
                        input logic [W-1:0] lo, input logic dbz);
    int edges;
    launch(tag, op, a, b, edges);
    wait_valid(edges);
    check_result(tag, edges, exp_latency(op, a, b), hi, lo, dbz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t           vecs[$];
    logic [W-1:0]   mhi, mlo;
    logic           mdbz;
    int             edges, lat, gap, nvalid;
    mdu_op_e        rop;
    logic [W-1:0]   ra, rb;

    bus.start    = 1'b0;
    bus.op       = MDU_MULTU;
    bus.Operand1 = '0;
    bus.Operand2 = '0;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    check("reset hi",    64'(bus.hi),    64'(0));
    check("reset lo",    64'(bus.lo),    64'(0));
    check("reset valid", 64'(bus.valid), 64'(0));
    check("reset busy",  64'(bus.busy),  64'(0));
    check("reset dbz",   64'(bus.div_by_zero), 64'(0));
    @(negedge CLK);
    RST = 1'b1;

    // Directed vectors.
    vecs.push_back('{MDU_MULTU, 32'd8,        32'd9,        32'h0,        32'h48,       1'b0});
    vecs.push_back('{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
    vecs.push_back('{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        1'b0});
    vecs.push_back('{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0});
    vecs.push_back('{MDU_MULTU, 32'd8,        32'd3,        32'h0,        32'd24,       1'b0});
    vecs.push_back('{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
    vecs.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0});
    vecs.push_back('{MDU_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{MDU_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 1'b0});
    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dbz);

    // start while busy is dropped; start in the valid cycle is accepted.
    lat = exp_latency(MDU_MULTU, 32'd6, 32'd7);
    gap = (lat > 12) ? 10 : 2;
    launch("busy_ign", MDU_MULTU, 32'd6, 32'd7, edges);
    for (int i = 0; i < gap - 1; i++) begin
      @(posedge CLK);
      #1;
      edges++;
    end
    @(negedge CLK);
    bus.start    = 1'b1;
    bus.op       = MDU_MULTU;
    bus.Operand1 = 32'd2;
    bus.Operand2 = 32'd2;
    @(posedge CLK);
    #1;
    edges++;
    bus.start = 1'b0;
    wait_valid(edges);
    check_result("busy_ign", edges, lat, 32'd0, 32'd42, 1'b0);
    bus.start    = 1'b1;
    bus.op       = MDU_MULTU;
    bus.Operand1 = 32'd3;
    bus.Operand2 = 32'd3;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    edges = 1;
    check("valid_cycle_start valid_one_cycle", 64'(bus.valid), 64'(0));
    check("valid_cycle_start busy", 64'(bus.busy), 64'(1));
    wait_valid(edges);
    check_result("valid_cycle_start", edges, exp_latency(MDU_MULTU, 32'd3, 32'd3),
                 32'd0, 32'd9, 1'b0);

    // Reset mid-divide aborts the operation.
    launch("rst_abort", MDU_DIVU, 32'd100, 32'd7, edges);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_abort hi",    64'(bus.hi),    64'(0));
    check("rst_abort lo",    64'(bus.lo),    64'(0));
    check("rst_abort valid", 64'(bus.valid), 64'(0));
    check("rst_abort busy",  64'(bus.busy),  64'(0));
    @(negedge CLK);
    RST = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      #1;
      if (bus.valid === 1'b1) nvalid++;
    end
    check("rst_abort no_valid", 64'(nvalid), 64'(0));

    // Random operations against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      rop = mdu_op_e'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, mhi, mlo, mdbz);
      run_op($sformatf("rand%0d op%0d %h,%h", i, rop, ra, rb), rop, ra, rb, mhi, mlo, mdbz);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
